// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch front-end and the decode stage.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush beats push and pop in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Credit-based instruction prefetcher with redirect flush and response discard.
// Optional IFETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module ifetch_prefetch_unit
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, rsp_pc_q, redirect_tgt;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    fetch_entry_t  fifo_head, push_entry;
    logic          req_fire, rsp_ok, rsp_drop, rsp_push, out_pop;

    assign redirect_tgt  = redirect_pc & 32'hFFFF_FFFC;
    assign mem_req_valid = !reset && !redirect_valid &&
                           (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;

    assign req_fire = mem_req_valid && mem_req_ready;
    assign rsp_ok   = mem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = rsp_ok && (discard_q != '0);
    assign rsp_push = rsp_ok && (discard_q == '0);

    assign out_valid = !reset && !fifo_empty;
    assign out_pop   = out_valid && out_ready;
    assign out_instr = out_valid ? fifo_head.instr : '0;
    assign out_pc    = out_valid ? fifo_head.pc    : '0;

    assign push_entry.pc    = rsp_pc_q;
    assign push_entry.instr = mem_rsp_data;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_push),
        .pop       (out_pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Every response still owed at a redirect belongs to the old stream.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !rsp_ok)
            outstanding_d = outstanding_q + CW'(1);
        else if (!req_fire && rsp_ok)
            outstanding_d = outstanding_q - CW'(1);
        discard_d = discard_q;
        if (rsp_drop)
            discard_d = discard_q - CW'(1);
        if (redirect_valid)
            discard_d = outstanding_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            rsp_pc_q      <= RESET_PC & 32'hFFFF_FFFC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_tgt;
                rsp_pc_q   <= redirect_tgt;
            end else begin
                if (req_fire)
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                if (rsp_push)
                    rsp_pc_q <= rsp_pc_q + 32'd4;
            end
            assert (!(mem_rsp_valid && outstanding_q == '0));
            assert (!(rsp_push && fifo_full && !out_pop));
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_flushed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (out_pop && !redirect_valid)
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect_valid)
                perf_flushed_q <= perf_flushed_q + 32'(fifo_count) + 32'(rsp_push) + 32'(rsp_drop);
            else if (rsp_drop)
                perf_flushed_q <= perf_flushed_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
